// File: rtl/ex_div_unit_pkg.sv
// ex_div_unit_pkg: shared types and constants for the EX-stage divider.
//   div_state_e       : divider FSM states (free, divide-by-zero, running, done)
//   DIV_RESULT_WD     : width of the {HI, LO} result bus toward the HI/LO path
//   DIV_RESULT_READY  : level of ready when a result is presented
package ex_div_unit_pkg;

    localparam int unsigned DIV_RESULT_WD = 64;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

endpackage

// File: rtl/ex_div_unit_abs.sv
// ex_div_unit_abs: conditional two's-complement negate.
//   value_i : operand
//   neg_i   : 1 = output -value_i, 0 = pass value_i through
//   value_o : result (wraps, so the most negative value maps to itself)
// Used both to take magnitudes of the operands and to restore the signs of
// quotient and remainder.
module ex_div_unit_abs #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] value_o
);

    always_comb begin
        value_o = value_i;
        if (neg_i) begin
            value_o = ~value_i + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative radix-2 restoring divider for DIV/DIVU in EX.
//   clk, rst   : clock, synchronous active-high reset
//   start      : DIV/DIVU present in EX (held for the whole operation)
//   signed_div : 1 = DIV, 0 = DIVU; sampled with start in the free state
//   dividend   : rs value, sampled in the free state
//   divisor    : rt value, sampled in the free state
//   annul      : abort the operation in flight (flush/exception)
//   result     : {remainder, quotient}; nonzero only while ready=1
//   ready      : result valid, one-cycle pulse
//   stallreq   : hold IF..EX while the divider is occupied
// One quotient bit is produced per cycle, so a non-zero divisor takes 32
// cycles in DIV_ON. Divide by zero returns zero after a single cycle.
module ex_div_unit
    import ex_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stallreq
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;

    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   trial;
    logic             step_fits;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] quo_fixed;
    logic [WIDTH-1:0] rem_fixed;
    logic             last_iter;

    always_comb begin
        dividend_neg = signed_div & dividend[WIDTH-1];
        divisor_neg  = signed_div & divisor[WIDTH-1];
    end

    ex_div_unit_abs #(.WIDTH(WIDTH)) u_abs_dividend (
        .value_i (dividend),
        .neg_i   (dividend_neg),
        .value_o (dividend_abs)
    );

    ex_div_unit_abs #(.WIDTH(WIDTH)) u_abs_divisor (
        .value_i (divisor),
        .neg_i   (divisor_neg),
        .value_o (divisor_abs)
    );

    // One restoring step: {rem,quo} shifted left, the bit leaving quo enters
    // rem. The subtract is one bit wider so a borrow marks "does not fit".
    always_comb begin
        partial   = {rem_q, quo_q[WIDTH-1]};
        trial     = partial - {1'b0, dsr_q};
        step_fits = ~trial[WIDTH];
        step_rem  = step_fits ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
        step_quo  = {quo_q[WIDTH-2:0], step_fits};
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Sign restoration is folded into the final step so DIV_END already
    // holds the architectural result.
    ex_div_unit_abs #(.WIDTH(WIDTH)) u_abs_quo (
        .value_i (step_quo),
        .neg_i   (neg_quo_q),
        .value_o (quo_fixed)
    );

    ex_div_unit_abs #(.WIDTH(WIDTH)) u_abs_rem (
        .value_i (step_rem),
        .neg_i   (neg_rem_q),
        .value_o (rem_fixed)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dsr_d     = dsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        unique case (state_q)
            DIV_FREE: begin
                if (start && !annul) begin
                    rem_d     = '0;
                    quo_d     = dividend_abs;
                    dsr_d     = divisor_abs;
                    neg_quo_d = dividend_neg ^ divisor_neg;
                    neg_rem_d = dividend_neg;
                    cnt_d     = '0;
                    state_d   = (divisor == '0) ? DIV_BYZERO : DIV_ON;
                end
            end
            DIV_ON: begin
                cnt_d = cnt_q + CNT_W'(1);
                rem_d = step_rem;
                quo_d = step_quo;
                if (last_iter) begin
                    rem_d   = rem_fixed;
                    quo_d   = quo_fixed;
                    cnt_d   = '0;
                    state_d = DIV_END;
                end
            end
            DIV_BYZERO: begin
                rem_d   = '0;
                quo_d   = '0;
                state_d = DIV_END;
            end
            DIV_END: begin
                state_d = DIV_FREE;
            end
            default: begin
                state_d = DIV_FREE;
            end
        endcase

        // Abort wins over everything, including a start in the same cycle.
        if (annul) begin
            state_d = DIV_FREE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dsr_q     <= dsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    always_comb begin
        ready    = (state_q == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
        result   = ready ? {rem_q, quo_q} : '0;
        stallreq = ((state_q == DIV_FREE) && start && !annul) ||
                   (state_q == DIV_ON) || (state_q == DIV_BYZERO);
    end

endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: directed vector table, hand-written
// annul/reset/back-to-back sequences, and randomized operations checked
// against an arithmetic reference model.
module tb_ex_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stallreq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stallreq   (stallreq)
    );

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: MIPS-style division, truncating toward zero; HI = remainder
    // with the sign of the dividend; divide by zero gives all zeros.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    // Called just after a rising edge; that cycle is cycle 0.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        signed_div = s;
        dividend   = a;
        divisor    = b;
        annul      = 1'b0;
        start      = 1'b1;
    endtask

    // Counts cycles from the issue cycle to the ready pulse, verifying that
    // stallreq is high before ready and low with it. Returns just after the
    // rising edge that ends the ready cycle.
    task automatic wait_ready(output int lat, output logic [63:0] res, output int stall_bad);
        lat       = -1;
        res       = '1;
        stall_bad = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (ready) begin
                res = result;
                if (stallreq) stall_bad++;
                lat = n;
                break;
            end
            if (!stallreq) stall_bad++;
            if (n == 1) begin
                dividend = $urandom;
                divisor  = $urandom;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int exp_lat);
        int          lat;
        int          sb;
        logic [63:0] res;
        issue(s, a, b);
        wait_ready(lat, res, sb);
        start = 1'b0;
        check64({name, " result"}, res, exp);
        check_int({name, " latency"}, lat, exp_lat);
        check_int({name, " stallreq"}, sb, 0);
    endtask

    initial begin
        int          lat1, lat2, sb1, sb2, pulses;
        logic [63:0] res1, res2;
        logic        s;
        logic [31:0] a, b;

        vecs.push_back('{1'b0, 32'd100,        32'd7,          32'h0000000E, 32'h00000002, 33});
        vecs.push_back('{1'b1, 32'hFFFFFFF9,   32'h00000002,   32'hFFFFFFFD, 32'hFFFFFFFF, 33});
        vecs.push_back('{1'b1, 32'h00000007,   32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001, 33});
        vecs.push_back('{1'b0, 32'hFFFFFFFF,   32'h00000001,   32'hFFFFFFFF, 32'h00000000, 33});
        vecs.push_back('{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000, 33});
        vecs.push_back('{1'b0, 32'd1234,       32'd0,          32'h00000000, 32'h00000000, 2});
        vecs.push_back('{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'h0000000E, 32'hFFFFFFFE, 33});
        vecs.push_back('{1'b0, 32'd5,          32'd9,          32'h00000000, 32'h00000005, 33});
        vecs.push_back('{1'b1, 32'hFFFFFFFB,   32'd0,          32'h00000000, 32'h00000000, 2});
        vecs.push_back('{1'b0, 32'hFFFFFFF9,   32'h00000002,   32'h7FFFFFFC, 32'h00000001, 33});

        rst        = 1'b1;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        dividend   = '0;
        divisor    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check64("reset outputs", {result, ready, stallreq}, 66'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check64("idle outputs", {result, ready, stallreq}, 66'd0);
        @(posedge clk);
        #1;

        // Directed vector table.
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b,
                   {vecs[i].hi, vecs[i].lo}, vecs[i].lat);
        end

        // annul together with start in the free state: nothing starts.
        issue(1'b0, 32'd10, 32'd2);
        annul = 1'b1;
        @(negedge clk);
        check_int("annul+start stallreq", int'(stallreq), 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        annul = 1'b0;
        @(negedge clk);
        check_int("annul+start ready", int'(ready), 0);
        @(posedge clk);
        #1;

        // annul in cycle 10 of a run.
        issue(1'b0, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        annul = 1'b1;
        @(posedge clk);
        #1;
        annul = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check64("after annul outputs", {result, ready, stallreq}, 66'd0);
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ready || stallreq) pulses++;
        end
        check_int("after annul activity", pulses, 0);
        @(posedge clk);
        #1;
        run_op("post-annul 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        // rst in cycle 20 of a run.
        issue(1'b1, 32'd1000, 32'd3);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check64("after rst outputs", {result, ready, stallreq}, 66'd0);
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        check_int("after rst ready", pulses, 0);
        @(posedge clk);
        #1;
        run_op("post-rst 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        // Back-to-back: restart the cycle right after the ready pulse.
        issue(1'b0, 32'd50, 32'd5);
        wait_ready(lat1, res1, sb1);
        issue(1'b0, 32'd81, 32'd9);
        wait_ready(lat2, res2, sb2);
        start = 1'b0;
        check_int("b2b first ready cycle", lat1, 33);
        check_int("b2b second ready cycle", lat1 + 1 + lat2, 67);
        check64("b2b first result", res1, {32'd0, 32'd10});
        check64("b2b second result", res2, {32'd0, 32'd9});
        check_int("b2b stallreq", sb1 + sb2, 0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'(-int'($urandom_range(1, 100)));
                3:       b = 32'd0;
                default: b = a >> $urandom_range(0, 31);
            endcase
            if (i == 0) a = 32'h80000000;
            run_op($sformatf("rand%0d", i), s, a, b, ref_div(s, a, b), (b == 32'd0) ? 2 : 33);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Iterative 32-bit divider for the EX stage; executes DIV/DIVU.
- Raises a stall request on the stall bus while busy, so IF..EX hold and MEM receives bubbles.
- Delivers {HI = remainder, LO = quotient} to EX, which forwards them toward the HI/LO write path.
- Radix-2 restoring algorithm: one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are WIDTH bits each.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  EX holds high for the whole time a DIV/DIVU sits in EX
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start in IDLE
- dividend  in  WIDTH  rs value; sampled in IDLE
- divisor  in  WIDTH  rt value; sampled in IDLE
- annul  in  1  abort the current operation (flush or exception)
- result  out  2*WIDTH  {remainder, quotient}; valid only while ready=1
- ready  out  1  result valid this cycle
- stallreq  out  1  stall request into the stall controller

Behaviour:
- Reset: state=IDLE, counter=0, internal registers=0, result=0, ready=0, stallreq=0.
- States:
  - IDLE: start=1 and annul=0 → latch abs(dividend), abs(divisor), sign flags.
    - divisor==0 → BYZERO
    - otherwise → RUN with counter=0
  - RUN: each cycle shift {rem,quo} left by 1; trial-subtract the divisor from rem (WIDTH+1-bit subtract); if non-negative, keep the difference and set quo[0]=1.
    - counter increments each cycle; after the 32nd iteration (counter==WIDTH-1) → DONE.
  - BYZERO: force rem=0, quo=0 → DONE. Architecturally undefined; this is the fixed team choice.
  - DONE: ready=1 and result driven. Next edge → IDLE regardless of start. EX consumes the result in this cycle.
- Latency:
  - Start seen in IDLE at cycle 0 → ready=1 in cycle 33 (32 RUN cycles).
  - Divide by zero → ready=1 in cycle 2.
  - ready is high for exactly one cycle.
- stallreq = (state==IDLE && start && !annul) || state==RUN || state==BYZERO. It is 0 in DONE so the pipeline advances in the same cycle ready=1.
- Sign fix-up, applied on entry to DONE:
  - quotient negated if signed_div and the operand signs differ;
  - remainder negated if signed_div and the dividend is negative.
  - Unsigned: no fix-up.
- 0x80000000 / 0xFFFFFFFF signed: wraps to quotient 0x80000000, remainder 0; no trap.
- annul: in any state → IDLE at the next edge, ready=0, stallreq=0 in the following cycle; overrides start in the same cycle. An operation in flight is discarded and has no effect on HI/LO.
- rst mid-operation: identical to reset values at the next edge; no partial result is visible.
- Back-to-back DIVs: a second start is seen in IDLE the cycle after DONE. The earliest restart is therefore 1 cycle after ready.
- Operands are registered at start; changes on dividend/divisor during RUN are ignored.

Decomposition:
- Shared defines header (lib/defines.vh): state encodings DivFree, DivByZero, DivOn, DivEnd; DivResultReady / DivResultNotReady; a DIV_RESULT_WD=64 width macro alongside the existing pipeline-bus width macros.
- No sub-module needed. An optional div_abs helper for the conditional two's-complement negate may be reused for operands and result fix-up.

Test Plan:
- DIVU 100/7: start at cycle 0 → ready only in cycle 33, result lo=14 (0x0000000E), hi=2; stallreq=1 for cycles 0-32, 0 in cycle 33.
- DIV -7/2 (0xFFFFFFF9 / 0x00000002) → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV 7/-2 → lo=0xFFFFFFFD, hi=0x00000001.
- DIVU 0xFFFFFFFF/1 → lo=0xFFFFFFFF, hi=0; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero, 1234/0 → ready in cycle 2, result=0; stallreq high in cycles 0-1 only.
- annul asserted in cycle 10 of a run → state IDLE in cycle 11, ready never asserts. rst in cycle 20 of a run → all outputs 0 in cycle 21. A new DIVU 9/3 after either completes in 33 cycles with lo=3, hi=0.
- Two back-to-back DIVUs, 50/5 then 81/9 → ready pulses in cycles 33 and 67 (restart seen cycle 34); results lo=10, hi=0 then lo=9, hi=0.
